// File: rtl/serial_paralelo_rx.sv
// Purpose : 1-bit line deserialiser; aligns on COM, reports IDLE/data bytes once ACTIVE.
// Latency : outputs reflect a byte on the same edge that samples its last bit (registered).
// Backpressure: none; the line never stalls, every byte is reported once per 8 clk_32f.
// Optional: define RX_BYTE_CNT_EN to add the saturating byte_count output.
module serial_paralelo_rx #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDLE_SYM  = 8'h7C,
    parameter int         BC_NEEDED = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        IDLE_OUT,
    output logic        active,
    output logic        byte_strobe
`ifdef RX_BYTE_CNT_EN
    ,
    output logic [15:0] byte_count
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] BC_N = BC_NEEDED[3:0];

    state_t      r_state;
    state_t      w_state_nxt;
    // Only the 7 most recent bits are needed: the 8th comes straight from data_in.
    logic [6:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_bc_cnt;

    logic [7:0]  w_nb;
    logic        w_is_com;
    logic        w_is_idle;
    logic        w_boundary;
    logic [3:0]  w_bc_inc;

    assign w_nb       = {r_sr, data_in};
    assign w_is_com   = (w_nb == COM_SYM);
    assign w_is_idle  = (w_nb == IDLE_SYM);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_bc_inc   = r_bc_cnt + 4'd1;

    // State register.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: bit-wise COM search, then COM counting on byte boundaries.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_is_com) begin
                    w_state_nxt = (BC_N == 4'd1) ? ST_ACTIVE : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (!w_is_com) begin
                        w_state_nxt = ST_HUNT;
                    end else if (w_bc_inc == BC_N) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                // Sticky until reset; no loss-of-sync detection.
                w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Shift register, bit/COM counters and registered byte classification.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_bc_cnt    <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            IDLE_OUT    <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
`ifdef RX_BYTE_CNT_EN
            byte_count  <= '0;
`endif
        end else begin
            r_sr        <= w_nb[6:0];
            active      <= (w_state_nxt == ST_ACTIVE);
            byte_strobe <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_bc_cnt  <= 4'd1;
                    end
                end
                ST_ALIGN: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        r_bc_cnt <= w_is_com ? w_bc_inc : 4'd0;
                    end
                end
                ST_ACTIVE: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        byte_strobe <= 1'b1;
                        if (w_is_com) begin
                            valid_out <= 1'b0;
                            IDLE_OUT  <= 1'b0;
                        end else if (w_is_idle) begin
                            valid_out <= 1'b0;
                            IDLE_OUT  <= 1'b1;
                        end else begin
                            data_out  <= w_nb;
                            valid_out <= 1'b1;
                            IDLE_OUT  <= 1'b0;
`ifdef RX_BYTE_CNT_EN
                            if (byte_count != 16'hFFFF) begin
                                byte_count <= byte_count + 16'd1;
                            end
`endif
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Testbench for serial_paralelo_rx: randomized and directed bit streams
// checked every cycle against a byte-level reference model of the receiver.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;
    localparam int         BCN = 4;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic        data_in = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        IDLE_OUT;
    logic        active;
    logic        byte_strobe;
`ifdef RX_BYTE_CNT_EN
    logic [15:0] byte_count;
`endif

    serial_paralelo_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .IDLE_OUT    (IDLE_OUT),
        .active      (active),
        .byte_strobe (byte_strobe)
`ifdef RX_BYTE_CNT_EN
        ,
        .byte_count  (byte_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int          checks = 0;
    int          errors = 0;
    bit          hist[$];   // every bit received since the last reset
    bit          stim[$];   // stimulus for the current scenario
    logic [27:0] exp_vec = '0;

    // ---------------- reference model ----------------
    // Byte whose last bit is hist[e]; bits before reset read as 0.
    function automatic logic [7:0] win(int e);
        logic [7:0] v;
        v = '0;
        for (int k = e - 7; k <= e; k++) begin
            v = {v[6:0], (k >= 0 && k < hist.size()) ? hist[k] : 1'b0};
        end
        return v;
    endfunction

    // Index of the last bit of the COM that completes alignment, or -1.
    function automatic int find_align();
        int n;
        int pos;
        n   = hist.size();
        pos = 0;
        while (pos < n) begin
            if (win(pos) == COM) begin
                int p;
                int k;
                bit fail;
                p = pos; k = 1; fail = 0;
                while (k < BCN && !fail) begin
                    if (p + 8 >= n) return -1;
                    p += 8;
                    if (win(p) == COM) k++;
                    else fail = 1;
                end
                if (!fail) return p;
                pos = p + 1;   // skipped windows are never rescanned
            end else begin
                pos++;
            end
        end
        return -1;
    endfunction

    // {count, data, valid, idle, active, strobe} expected after the latest bit.
    function automatic logic [27:0] model();
        int          a;
        int          m;
        int          cnt;
        logic [7:0]  d;
        logic [7:0]  by;
        logic        v;
        logic        i;
        logic        s;
        logic [15:0] c16;
        a = find_align();
        m = hist.size() - 1;
        d = '0; v = 0; i = 0; s = 0; cnt = 0;
        if (a < 0) return '0;
        for (int c = a + 8; c <= m; c += 8) begin
            by = win(c);
            if (by == COM) begin
                v = 0; i = 0;
            end else if (by == IDL) begin
                v = 0; i = 1;
            end else begin
                d = by; v = 1; i = 0;
                if (cnt < 65535) cnt++;
            end
            s = (c == m);
        end
`ifdef RX_BYTE_CNT_EN
        c16 = cnt[15:0];
`else
        c16 = 16'h0;
`endif
        return {c16, d, v, i, 1'b1, s};
    endfunction

    function automatic logic [27:0] obs();
        logic [15:0] c16;
`ifdef RX_BYTE_CNT_EN
        c16 = byte_count;
`else
        c16 = 16'h0;
`endif
        return {c16, data_out, valid_out, IDLE_OUT, active, byte_strobe};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic void add_byte(logic [7:0] by);
        for (int k = 7; k >= 0; k--) stim.push_back(by[k]);
    endfunction

    function automatic logic [7:0] rand_data();
        logic [7:0] by;
        by = 8'($urandom_range(0, 255));
        while (by == COM || by == IDL) by = 8'($urandom_range(0, 255));
        return by;
    endfunction

    task automatic step_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        hist.push_back(b);
        exp_vec = model();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'($urandom_range(0, 1));
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        hist.delete();
        exp_vec = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
        end
        do_reset();
        checks++;
        if (obs() !== 28'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs(), 28'h0);
        end
    endtask

    task automatic test_align();
        do_reset();
        stim.delete();
        stim.push_back(1); stim.push_back(0); stim.push_back(1);
        repeat (4) add_byte(COM);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL align bit%0d: got %h want %h", j, obs(), exp_vec);
            end
            if (j == stim.size() - 2) begin
                checks++;
                if (active !== 1'b0) begin
                    errors++;
                    $display("FAIL align_early: active=%b want 0", active);
                end
            end
        end
        checks++;
        if (obs() !== 28'h2) begin
            errors++;
            $display("FAIL align_done: got %h want %h", obs(), 28'h2);
        end
    endtask

    task automatic test_data();
        logic [7:0] exp_b[4];
        int n_stb;
        int last_stb;
        exp_b[0] = 8'hFF; exp_b[1] = 8'hEE; exp_b[2] = 8'hDD; exp_b[3] = 8'hCC;
        n_stb = 0; last_stb = -1;
        stim.delete();
        foreach (exp_b[b]) add_byte(exp_b[b]);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL data bit%0d: got %h want %h", j, obs(), exp_vec);
            end
            if (byte_strobe === 1'b1) begin
                if (last_stb >= 0) begin
                    checks++;
                    if (j - last_stb != 8) begin
                        errors++;
                        $display("FAIL strobe_spacing: got %0d want 8", j - last_stb);
                    end
                end
                last_stb = j;
                n_stb++;
            end
            if (j % 8 == 7) begin
                checks++;
                if (data_out !== exp_b[j / 8] || valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL data_byte%0d: got %h/%b want %h/1", j / 8, data_out, valid_out, exp_b[j / 8]);
                end
            end
        end
        checks++;
        if (n_stb != 4) begin
            errors++;
            $display("FAIL strobe_count: got %0d want 4", n_stb);
        end
    endtask

    task automatic test_idle();
        int n_idle;
        n_idle = 0;
        stim.delete();
        add_byte(IDL); add_byte(IDL); add_byte(8'h55);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL idle bit%0d: got %h want %h", j, obs(), exp_vec);
            end
            if (IDLE_OUT === 1'b1) n_idle++;
        end
        checks++;
        if (n_idle != 16) begin
            errors++;
            $display("FAIL idle_len: got %0d want 16", n_idle);
        end
        checks++;
        if (data_out !== 8'h55 || valid_out !== 1'b1 || IDLE_OUT !== 1'b0) begin
            errors++;
            $display("FAIL idle_then_data: got %h/%b/%b want 55/1/0", data_out, valid_out, IDLE_OUT);
        end
    endtask

    task automatic test_false_com();
        int n_act;
        n_act = 0;
        do_reset();
        stim.delete();
        add_byte(COM); add_byte(COM); add_byte(8'h55);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL false_com bit%0d: got %h want %h", j, obs(), exp_vec);
            end
            if (active !== 1'b0) n_act++;
        end
        checks++;
        if (n_act != 0) begin
            errors++;
            $display("FAIL false_com_active: got %0d active cycles want 0", n_act);
        end
        stim.delete();
        repeat (4) add_byte(COM);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL realign bit%0d: got %h want %h", j, obs(), exp_vec);
            end
        end
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL realign_done: active=%b want 1", active);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        stim.delete();
        repeat (4) add_byte(COM);
        add_byte(8'h3A);
        for (int k = 7; k >= 4; k--) stim.push_back(k[0]);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL pre_reset bit%0d: got %h want %h", j, obs(), exp_vec);
            end
        end
        do_reset();
        checks++;
        if (obs() !== 28'h0) begin
            errors++;
            $display("FAIL midreset_state: got %h want %h", obs(), 28'h0);
        end
        stim.delete();
        repeat (3) add_byte(COM);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL post_reset bit%0d: got %h want %h", j, obs(), exp_vec);
            end
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL three_com_active: active=%b want 0", active);
        end
        stim.delete();
        add_byte(COM);
        add_byte(8'h3A);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL post_reset2 bit%0d: got %h want %h", j, obs(), exp_vec);
            end
        end
        checks++;
        if (data_out !== 8'h3A || valid_out !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL reset_realign: got %h/%b/%b want 3a/1/1", data_out, valid_out, active);
        end
    endtask

    task automatic test_random_traffic();
        int r;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            stim.delete();
            repeat ($urandom_range(0, 15)) stim.push_back(1'($urandom_range(0, 1)));
            repeat (BCN) add_byte(COM);
            repeat (40) begin
                r = $urandom_range(0, 9);
                if (r == 0) add_byte(COM);
                else if (r == 1) add_byte(IDL);
                else add_byte(rand_data());
            end
            foreach (stim[j]) begin
                step_bit(stim[j]);
                checks++;
                if (obs() !== exp_vec) begin
                    errors++;
                    $display("FAIL random%0d bit%0d: got %h want %h", it, j, obs(), exp_vec);
                end
            end
        end
    endtask

`ifdef RX_BYTE_CNT_EN
    task automatic test_byte_count();
        do_reset();
        stim.delete();
        repeat (4) add_byte(COM);
        repeat (3) add_byte(rand_data());
        add_byte(COM);
        add_byte(IDL);
        foreach (stim[j]) begin
            step_bit(stim[j]);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL bytecnt bit%0d: got %h want %h", j, obs(), exp_vec);
            end
        end
        checks++;
        if (byte_count !== 16'd3) begin
            errors++;
            $display("FAIL byte_count: got %0d want 3", byte_count);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_align();
        test_data();
        test_idle();
        test_false_com();
        test_midstream_reset();
        test_random_traffic();
`ifdef RX_BYTE_CNT_EN
        test_byte_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
